// File: rtl/vt52_pkg.sv
// Shared types and character constants for the VT52 byte-stream interpreter.
package vt52_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC,
    ST_ESC_Y_ROW,
    ST_ESC_Y_COL,
    ST_FILL
  } state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_HT    = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;

  localparam logic [7:0] ESC_UP      = 8'h41; // A
  localparam logic [7:0] ESC_DOWN    = 8'h42; // B
  localparam logic [7:0] ESC_RIGHT   = 8'h43; // C
  localparam logic [7:0] ESC_LEFT    = 8'h44; // D
  localparam logic [7:0] ESC_HOME    = 8'h48; // H
  localparam logic [7:0] ESC_RLF     = 8'h49; // I
  localparam logic [7:0] ESC_ERA_EOS = 8'h4A; // J
  localparam logic [7:0] ESC_ERA_EOL = 8'h4B; // K
  localparam logic [7:0] ESC_ADDR    = 8'h59; // Y

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/vt52_fill_engine.sv
// Writes a run of cells one per clock from a start address, wrapping at the end of memory.
module vt52_fill_engine #(
  parameter int unsigned CELLS  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 11
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy_q <= 1'b0;
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  // rem_q counts cells still to write after the current one.
  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    rem_d  = rem_q;
    if (start_i) begin
      busy_d = 1'b1;
      addr_d = start_addr_i;
      rem_d  = count_i - CNT_W'(1);
    end else if (busy_q) begin
      if (rem_q == '0) begin
        busy_d = 1'b0;
      end else begin
        rem_d  = rem_q - CNT_W'(1);
        addr_d = (addr_q == ADDR_W'(CELLS - 1)) ? '0 : addr_q + ADDR_W'(1);
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (rem_q == '0);
  assign addr_o = addr_q;

endmodule

// File: rtl/vt52_command_handler.sv
// VT52 byte interpreter: decodes printables, controls and escapes; drives char/cursor memories.
module vt52_command_handler
  import vt52_pkg::*;
#(
  parameter int unsigned COLS   = 64,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned TAB    = 8,
  parameter int unsigned COL_W  = $clog2(COLS),
  parameter int unsigned ROW_W  = $clog2(ROWS),
  parameter int unsigned ADDR_W = $clog2(COLS*ROWS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        data,
  input  logic              valid,
  output logic              ready,
  output logic [ADDR_W-1:0] char_addr,
  output logic [7:0]        char_data,
  output logic              char_wen,
  output logic [COL_W-1:0]  cursor_x,
  output logic [ROW_W-1:0]  cursor_y,
  output logic              cursor_wen,
  output logic [ROW_W-1:0]  first_row,
  output logic              first_row_wen
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  cx_q, cx_d;
  logic [ROW_W-1:0]  cy_q, cy_d;
  logic [ROW_W-1:0]  fr_q, fr_d;
  logic [7:0]        row_q, row_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              cwen_q, cwen_d;
  logic              frwen_q, frwen_d;

  logic              fill_start, fill_busy, fill_done;
  logic [ADDR_W-1:0] fill_start_addr, fill_addr;
  logic [CNT_W-1:0]  fill_count;

  logic              accept;
  logic [ROW_W:0]    psum;
  logic [ROW_W-1:0]  prow;
  logic [ADDR_W-1:0] cur_paddr;
  logic [COL_W:0]    tab_nx;
  logic [ROW_W-1:0]  fr_inc, fr_dec;
  logic [7:0]        col_c;

  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
    return ADDR_W'(r) * ADDR_W'(COLS);
  endfunction

  assign ready  = (state_q != ST_FILL);
  assign accept = valid && ready;

  // Logical row is offset by the scroll pointer, modulo ROWS.
  assign psum      = {1'b0, cy_q} + {1'b0, fr_q};
  assign prow      = (psum >= (ROW_W+1)'(ROWS)) ? ROW_W'(psum - (ROW_W+1)'(ROWS)) : psum[ROW_W-1:0];
  assign cur_paddr = row_base(prow) + ADDR_W'(cx_q);
  assign tab_nx    = ({1'b0, cx_q} | (COL_W+1)'(TAB - 1)) + (COL_W+1)'(1);
  assign fr_inc    = (fr_q == ROW_W'(ROWS - 1)) ? '0 : fr_q + ROW_W'(1);
  assign fr_dec    = (fr_q == '0) ? ROW_W'(ROWS - 1) : fr_q - ROW_W'(1);
  assign col_c     = data - CH_SPACE;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      fr_q    <= '0;
      row_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cwen_q  <= 1'b0;
      frwen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      fr_q    <= fr_d;
      row_q   <= row_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cwen_q  <= cwen_d;
      frwen_q <= frwen_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cx_d            = cx_q;
    cy_d            = cy_q;
    fr_d            = fr_q;
    row_d           = row_q;
    wr_d            = 1'b0;
    waddr_d         = waddr_q;
    wdata_d         = wdata_q;
    frwen_d         = 1'b0;
    fill_start      = 1'b0;
    fill_start_addr = '0;
    fill_count      = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(data)) begin
            wr_d    = 1'b1;
            waddr_d = cur_paddr;
            wdata_d = data;
            if (cx_q < COL_W'(COLS - 1)) cx_d = cx_q + COL_W'(1);
          end else begin
            case (data)
              CH_BS: if (cx_q > '0) cx_d = cx_q - COL_W'(1);
              CH_HT: begin
                if (tab_nx < (COL_W+1)'(COLS))     cx_d = tab_nx[COL_W-1:0];
                else if (cx_q < COL_W'(COLS - 1)) cx_d = cx_q + COL_W'(1);
              end
              CH_LF: begin
                if (cy_q < ROW_W'(ROWS - 1)) begin
                  cy_d = cy_q + ROW_W'(1);
                end else begin
                  // Old top row becomes the new bottom row and is blanked.
                  fr_d            = fr_inc;
                  frwen_d         = 1'b1;
                  fill_start      = 1'b1;
                  fill_start_addr = row_base(fr_q);
                  fill_count      = CNT_W'(COLS);
                  state_d         = ST_FILL;
                end
              end
              CH_CR:   cx_d = '0;
              CH_ESC:  state_d = ST_ESC;
              default: ;
            endcase
          end
        end
      end

      ST_ESC: begin
        if (accept) begin
          state_d = ST_IDLE;
          case (data)
            ESC_UP:    if (cy_q > '0) cy_d = cy_q - ROW_W'(1);
            ESC_DOWN:  if (cy_q < ROW_W'(ROWS - 1)) cy_d = cy_q + ROW_W'(1);
            ESC_RIGHT: if (cx_q < COL_W'(COLS - 1)) cx_d = cx_q + COL_W'(1);
            ESC_LEFT:  if (cx_q > '0) cx_d = cx_q - COL_W'(1);
            ESC_HOME: begin
              cx_d = '0;
              cy_d = '0;
            end
            ESC_RLF: begin
              if (cy_q > '0) begin
                cy_d = cy_q - ROW_W'(1);
              end else begin
                fr_d            = fr_dec;
                frwen_d         = 1'b1;
                fill_start      = 1'b1;
                fill_start_addr = row_base(fr_dec);
                fill_count      = CNT_W'(COLS);
                state_d         = ST_FILL;
              end
            end
            ESC_ERA_EOS: begin
              fill_start      = 1'b1;
              fill_start_addr = cur_paddr;
              fill_count      = CNT_W'(CELLS) - (CNT_W'(cy_q) * CNT_W'(COLS) + CNT_W'(cx_q));
              state_d         = ST_FILL;
            end
            ESC_ERA_EOL: begin
              fill_start      = 1'b1;
              fill_start_addr = cur_paddr;
              fill_count      = CNT_W'(COLS) - CNT_W'(cx_q);
              state_d         = ST_FILL;
            end
            ESC_ADDR: state_d = ST_ESC_Y_ROW;
            default:  ;
          endcase
        end
      end

      ST_ESC_Y_ROW: begin
        if (accept) begin
          row_d   = data - CH_SPACE;
          state_d = ST_ESC_Y_COL;
        end
      end

      ST_ESC_Y_COL: begin
        if (accept) begin
          if (32'(row_q) < ROWS) cy_d = ROW_W'(row_q);
          if (32'(col_c) < COLS) cx_d = COL_W'(col_c);
          state_d = ST_IDLE;
        end
      end

      ST_FILL: if (fill_done) state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    cwen_d = (cx_d != cx_q) || (cy_d != cy_q);
  end

  vt52_fill_engine #(
    .CELLS (CELLS),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_fill (
    .clk         (clk),
    .clr         (clr),
    .start_i     (fill_start),
    .start_addr_i(fill_start_addr),
    .count_i     (fill_count),
    .busy_o      (fill_busy),
    .done_o      (fill_done),
    .addr_o      (fill_addr)
  );

  assign char_wen      = wr_q | fill_busy;
  assign char_addr     = fill_busy ? fill_addr : waddr_q;
  assign char_data     = fill_busy ? CH_SPACE : wdata_q;
  assign cursor_x      = cx_q;
  assign cursor_y      = cy_q;
  assign cursor_wen    = cwen_q;
  assign first_row     = fr_q;
  assign first_row_wen = frwen_q;

endmodule

// File: tb/tb_vt52_command_handler.sv
// Scoreboard bench for vt52_command_handler: expected writes/cursor/scroll events queued, monitor compares.
module tb_vt52_command_handler;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [9:0] char_addr;
  logic [7:0] char_data;
  logic       char_wen;
  logic [5:0] cursor_x;
  logic [3:0] cursor_y;
  logic       cursor_wen;
  logic [3:0] first_row;
  logic       first_row_wen;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [17:0] wq[$];  // {addr, data}
  logic [9:0]  cq[$];  // {x, y}
  logic [3:0]  fq[$];

  always #5 clk = ~clk;

  vt52_command_handler #(
    .COLS(64),
    .ROWS(16),
    .TAB (8)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .char_addr    (char_addr),
    .char_data    (char_data),
    .char_wen     (char_wen),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .cursor_wen   (cursor_wen),
    .first_row    (first_row),
    .first_row_wen(first_row_wen)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event value %0h, expected no event", name, act);
  endtask

  // Monitor: pops expected events whenever the DUT strobes.
  always @(negedge clk) begin
    logic [17:0] w;
    logic [9:0]  c;
    logic [3:0]  f;
    if (char_wen === 1'b1) begin
      if (wq.size() == 0) unexpected("char_write", {14'b0, char_addr, char_data});
      else begin
        w = wq.pop_front();
        chk("char_addr", 32'(char_addr), 32'(w[17:8]));
        chk("char_data", 32'(char_data), 32'(w[7:0]));
      end
    end
    if (cursor_wen === 1'b1) begin
      if (cq.size() == 0) unexpected("cursor_wen", {22'b0, cursor_x, cursor_y});
      else begin
        c = cq.pop_front();
        chk("cursor_x", 32'(cursor_x), 32'(c[9:4]));
        chk("cursor_y", 32'(cursor_y), 32'(c[3:0]));
      end
    end
    if (first_row_wen === 1'b1) begin
      if (fq.size() == 0) unexpected("first_row_wen", 32'(first_row));
      else begin
        f = fq.pop_front();
        chk("first_row", 32'(first_row), 32'(f));
      end
    end
  end

  task automatic exp_wr(input int unsigned a, input logic [7:0] d);
    wq.push_back({10'(a), d});
  endtask

  task automatic exp_cur(input int unsigned x, input int unsigned y);
    cq.push_back({6'(x), 4'(y)});
  endtask

  task automatic exp_fill(input int unsigned start, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_wr((start + i) % 1024, 8'h20);
  endtask

  task automatic send(input logic [7:0] b);
    int unsigned n = 0;
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) unexpected("send_timeout", 32'(b));
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic esc_y(input logic [7:0] r, input logic [7:0] c);
    send(8'h1B);
    send(8'h59);
    send(r);
    send(c);
  endtask

  task automatic ready_low(input string name, input int unsigned n_exp);
    int unsigned n = 0;
    @(negedge clk);
    while (!ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, n_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    clr   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_char_wen", 32'(char_wen), 0);
    chk("rst_char_addr", 32'(char_addr), 0);
    chk("rst_cursor_x", 32'(cursor_x), 0);
    chk("rst_cursor_y", 32'(cursor_y), 0);
    chk("rst_first_row", 32'(first_row), 0);
    chk("rst_strobes", {30'b0, cursor_wen, first_row_wen}, 0);
    clr = 1'b0;

    // "Hi" at home
    exp_wr(0, 8'h48); exp_cur(1, 0); send(8'h48);
    exp_wr(1, 8'h69); exp_cur(2, 0); send(8'h69);

    // Tab at right margin, then from column 3
    exp_cur(62, 0); esc_y(8'h20, 8'h5E);
    exp_cur(63, 0); send(8'h09);
    send(8'h09);
    repeat (2) @(negedge clk);
    chk("tab_at_edge_x", 32'(cursor_x), 63);
    exp_cur(3, 0); esc_y(8'h20, 8'h23);
    exp_cur(8, 0); send(8'h09);

    // Direct addressing, including an out-of-range row
    exp_cur(10, 5); esc_y(8'h25, 8'h2A);
    esc_y(8'h40, 8'h2A);
    repeat (2) @(negedge clk);
    chk("escy_oor_y", 32'(cursor_y), 5);
    chk("escy_oor_x", 32'(cursor_x), 10);
    exp_cur(0, 5); send(8'h0D);
    send(8'h08);
    repeat (2) @(negedge clk);
    chk("bs_at_zero", 32'(cursor_x), 0);

    // LF on bottom row scrolls and blanks physical row 0
    exp_cur(0, 15); esc_y(8'h2F, 8'h20);
    fq.push_back(4'd1); exp_fill(0, 64);
    send(8'h0A);
    ready_low("scroll_ready_low", 64);
    chk("scroll_first_row", 32'(first_row), 1);
    chk("scroll_cursor_y", 32'(cursor_y), 15);

    // Erase to end of line and end of screen with first_row=1
    exp_cur(60, 15); esc_y(8'h2F, 8'h5C);
    exp_fill(60, 4);
    send(8'h1B); send(8'h4B);
    ready_low("eol_ready_low", 4);
    exp_cur(0, 0); send(8'h1B); send(8'h48);
    exp_fill(64, 1024);
    send(8'h1B); send(8'h4A);
    ready_low("eos_ready_low", 1024);

    // Reset in the middle of a fill
    exp_fill(64, 1024);
    send(8'h1B); send(8'h4A);
    repeat (10) @(negedge clk);
    #1 clr = 1'b1;
    chk("abort_pending", wq.size(), 1014);
    wq.delete();
    @(negedge clk);
    chk("abort_char_wen", 32'(char_wen), 0);
    chk("abort_ready", 32'(ready), 1);
    chk("abort_cursor", {26'b0, cursor_x, cursor_y}, 0);
    chk("abort_first_row", 32'(first_row), 0);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    // Reverse LF at top scrolls down and blanks new top row 15
    fq.push_back(4'd15); exp_fill(960, 64);
    send(8'h1B); send(8'h49);
    ready_low("rlf_ready_low", 64);

    // Unknown escape ignored; next printable lands at physical row 15
    send(8'h1B); send(8'h5A);
    exp_wr(960, 8'h41); exp_cur(1, 0); send(8'h41);
    repeat (4) @(negedge clk);

    chk("wq_empty", wq.size(), 0);
    chk("cq_empty", cq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
